// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter that shares one 8:1 structural mux
// among eight requesters. The registered grant drives the mux select, and
// each grant is bounded by a QUANTUM-cycle budget.
// Optional feature macro: MUX_ARB_LOCK_EN. When it is defined, the owner can
// hold lock=1 to keep the grant past quantum expiry.
// This file also holds the structural mux (mux8to1_str) and its 2:1 leaf cell.

module mux8_rr_arbiter #(
    parameter int QUANTUM = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] d,
    input  logic       lock,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       sel_vld,
    output logic       y
);

    localparam logic [7:0] QMAX = 8'(QUANTUM - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] cnt;

    logic [2:0] search_start;
    logic       found;
    logic [2:0] pick;
    logic       owner_req;
    logic       hold_past_quantum;
    logic       release_now;
    logic       mux_out;

`ifdef MUX_ARB_LOCK_EN
    assign hold_past_quantum = lock;
`else
    logic unused_lock;
    assign unused_lock       = lock;
    assign hold_past_quantum = 1'b0;
`endif

    // The owner gives up the mux when it stops requesting or its budget runs out.
    // When the lock feature is built in, lock=1 suppresses budget expiry.
    always_comb begin
        owner_req    = req[sel];
        release_now  = (state == GRANT) &&
                       (!owner_req || ((cnt == 8'd0) && !hold_past_quantum));
        search_start = (state == GRANT) ? (sel + 3'd1) : ptr;
    end

    // Find the first active requester, scanning the ring from search_start.
    always_comb begin
        logic [2:0] idx;
        found = 1'b0;
        pick  = 3'd0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = search_start + i[2:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Arbitration FSM. All outputs are registered here, so the select never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 3'd0;
            cnt     <= 8'd0;
            grant   <= 8'd0;
            sel     <= 3'd0;
            sel_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= GRANT;
                        grant   <= 8'b1 << pick;
                        sel     <= pick;
                        sel_vld <= 1'b1;
                        cnt     <= QMAX;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr <= sel + 3'd1;
                        if (found) begin
                            grant   <= 8'b1 << pick;
                            sel     <= pick;
                            sel_vld <= 1'b1;
                            cnt     <= QMAX;
                        end else begin
                            state   <= IDLE;
                            grant   <= 8'd0;
                            sel_vld <= 1'b0;
                        end
                    end else if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mux8to1_str u_mux (
        .d (d),
        .s (sel),
        .y (mux_out)
    );

    assign y = mux_out & sel_vld;

endmodule

// Structural 8:1 mux built as a tree of 2:1 cells; s[0] selects at the leaves.
module mux8to1_str (
    input  logic [7:0] d,
    input  logic [2:0] s,
    output logic       y
);

    logic [3:0] lvl0;
    logic [1:0] lvl1;

    mux2to1_str u_l0_0 (.a(d[0]),    .b(d[1]),    .s(s[0]), .y(lvl0[0]));
    mux2to1_str u_l0_1 (.a(d[2]),    .b(d[3]),    .s(s[0]), .y(lvl0[1]));
    mux2to1_str u_l0_2 (.a(d[4]),    .b(d[5]),    .s(s[0]), .y(lvl0[2]));
    mux2to1_str u_l0_3 (.a(d[6]),    .b(d[7]),    .s(s[0]), .y(lvl0[3]));
    mux2to1_str u_l1_0 (.a(lvl0[0]), .b(lvl0[1]), .s(s[1]), .y(lvl1[0]));
    mux2to1_str u_l1_1 (.a(lvl0[2]), .b(lvl0[3]), .s(s[1]), .y(lvl1[1]));
    mux2to1_str u_l2_0 (.a(lvl1[0]), .b(lvl1[1]), .s(s[2]), .y(y));

endmodule

// 2:1 leaf cell written as AND-OR logic.
module mux2to1_str (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    assign y = (a & ~s) | (b & s);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Testbench for mux8_rr_arbiter.
// The main vector table covers reset, a single requester, full rotation,
// owner drop, simultaneous drop/expiry, the idle hold of sel, and reset mid-grant.
// Hand-written sequences cover lock behaviour (MUX_ARB_LOCK_EN) and QUANTUM=1.

module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] d;
    logic       lock;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       sel_vld;
    logic       y;
    logic [7:0] grant_q1;
    logic [2:0] sel_q1;
    logic       sel_vld_q1;
    logic       y_q1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] d;
        logic       lock;
        logic [7:0] grant;
        logic [2:0] sel;
        logic       vld;
        logic       y;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.QUANTUM(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .d       (d),
        .lock    (lock),
        .grant   (grant),
        .sel     (sel),
        .sel_vld (sel_vld),
        .y       (y)
    );

    mux8_rr_arbiter #(.QUANTUM(1)) dut_q1 (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .d       (d),
        .lock    (lock),
        .grant   (grant_q1),
        .sel     (sel_q1),
        .sel_vld (sel_vld_q1),
        .y       (y_q1)
    );

    task automatic addVec(input logic r, input logic [7:0] rq, input logic [7:0] dd,
                          input logic lk, input logic [7:0] g, input logic [2:0] s,
                          input logic v, input logic yy);
        vec_t t;
        t.rst = r; t.req = rq; t.d = dd; t.lock = lk;
        t.grant = g; t.sel = s; t.vld = v; t.y = yy;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input logic r, input logic [7:0] rq, input logic [7:0] dd,
                                 input logic lk);
        @(negedge clk);
        rst  = r;
        req  = rq;
        d    = dd;
        lock = lk;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string what, input int idx,
                               input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s step%0d actual=%h required=%h", what, idx, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] dpat;
        logic [7:0] exp_g;
        int k;

        rst  = 1'b1;
        req  = 8'h00;
        d    = 8'h00;
        lock = 1'b0;
        dpat = 8'hA5;

        // Reset with every requester active: outputs stay at zero.
        addVec(1, 8'hFF, 8'hA5, 0, 8'h00, 3'd0, 0, 0);
        addVec(1, 8'hFF, 8'hA5, 0, 8'h00, 3'd0, 0, 0);

        // A lone requester 0 is re-granted back to back with no gap.
        for (int i = 0; i < 9; i++)
            addVec(0, 8'h01, 8'hA5, 0, 8'h01, 3'd0, 1, 1);

        // Full rotation: four cycles per owner, y follows d[sel].
        addVec(1, 8'h00, 8'hA5, 0, 8'h00, 3'd0, 0, 0);
        for (int i = 0; i < 36; i++) begin
            k = (i / 4) % 8;
            addVec(0, 8'hFF, 8'hA5, 0, 8'h01 << k, 3'(k), 1, dpat[k]);
        end

        // Owner 3 drops its request; the search starts at 4, so 7 wins.
        addVec(1, 8'h00, 8'hA5, 0, 8'h00, 3'd0, 0, 0);
        addVec(0, 8'h08, 8'hA5, 0, 8'h08, 3'd3, 1, 0);
        addVec(0, 8'h88, 8'hA5, 0, 8'h08, 3'd3, 1, 0);
        addVec(0, 8'h88, 8'hA5, 0, 8'h08, 3'd3, 1, 0);
        addVec(0, 8'h80, 8'hA5, 0, 8'h80, 3'd7, 1, 1);
        addVec(0, 8'h80, 8'hA5, 0, 8'h80, 3'd7, 1, 1);

        // Owner 2 drops its request in its expiry cycle: one release, then 5.
        addVec(1, 8'h00, 8'hA5, 0, 8'h00, 3'd0, 0, 0);
        addVec(0, 8'h04, 8'hA5, 0, 8'h04, 3'd2, 1, 1);
        addVec(0, 8'h24, 8'hA5, 0, 8'h04, 3'd2, 1, 1);
        addVec(0, 8'h24, 8'hA5, 0, 8'h04, 3'd2, 1, 1);
        addVec(0, 8'h24, 8'hA5, 0, 8'h04, 3'd2, 1, 1);
        addVec(0, 8'h20, 8'hA5, 0, 8'h20, 3'd5, 1, 1);
        addVec(0, 8'h20, 8'hA5, 0, 8'h20, 3'd5, 1, 1);

        // Going idle keeps sel at 5, and y is masked even though d[5]=1.
        addVec(0, 8'h00, 8'hA5, 0, 8'h00, 3'd5, 0, 0);
        addVec(0, 8'h00, 8'hA5, 0, 8'h00, 3'd5, 0, 0);

        // ptr is now 6, so requester 0 beats requester 5.
        addVec(0, 8'h21, 8'hA5, 0, 8'h01, 3'd0, 1, 1);

        // Reset mid-grant, then arbitration starts again from requester 0.
        addVec(1, 8'hFF, 8'hA5, 0, 8'h00, 3'd0, 0, 0);
        addVec(0, 8'hFF, 8'hA5, 0, 8'h01, 3'd0, 1, 1);
        addVec(0, 8'hFF, 8'h5A, 0, 8'h01, 3'd0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].d, vecs[i].lock);
            checkOutput("grant",   i, grant,            vecs[i].grant);
            checkOutput("sel",     i, {5'd0, sel},      {5'd0, vecs[i].sel});
            checkOutput("sel_vld", i, {7'd0, sel_vld},  {7'd0, vecs[i].vld});
            checkOutput("y",       i, {7'd0, y},        {7'd0, vecs[i].y});
        end

        // Lock sequence: owner 1 with lock=1 for 10 cycles, then lock drops.
        applyStimulus(1, 8'h00, 8'hA5, 0);
        checkOutput("lock_rst_grant", 0, grant, 8'h00);
        for (int r = 1; r <= 11; r++) begin
            applyStimulus(0, 8'h06, 8'hA5, (r <= 10) ? 1'b1 : 1'b0);
`ifdef MUX_ARB_LOCK_EN
            exp_g = (r <= 10) ? 8'h02 : 8'h04;
`else
            exp_g = (((r - 1) / 4) % 2 == 0) ? 8'h02 : 8'h04;
`endif
            checkOutput("lock_grant", r, grant, exp_g);
        end

        // QUANTUM=1 instance: one cycle per owner, strict rotation.
        applyStimulus(1, 8'h00, 8'hA5, 0);
        checkOutput("q1_rst_grant", 0, grant_q1, 8'h00);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 8'hFF, 8'hA5, 0);
            checkOutput("q1_grant", i, grant_q1, 8'h01 << (i % 8));
            checkOutput("q1_sel", i, {5'd0, sel_q1}, 8'(i % 8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
